// File: rtl/line_fanout.sv
// rtl/line_fanout.sv - two-line buffer feeding column-aligned row triples to a 3-line filter
module line_fanout #(
    parameter int LINE_WORDS = 128,
    parameter int ADDR_W     = 7
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_data_valid,
    input  logic [63:0] i_data,
    output logic        o_data_ack,
    output logic        o_line1_data_valid,
    output logic [63:0] o_line1_data,
    input  logic        i_line1_data_ack,
    output logic        o_line2_data_valid,
    output logic [63:0] o_line2_data,
    input  logic        i_line2_data_ack,
    output logic        o_line3_data_valid,
    output logic [63:0] o_line3_data,
    input  logic        i_line3_data_ack
);

    typedef enum logic {ST_FILL, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [1:0]        rows_q, rows_d;
    logic              old_sel_q, old_sel_d;
    logic              pending_q, pending_d;
    logic [2:0]        valid_q, valid_d;
    logic [63:0]       line1_q, line1_d;
    logic [63:0]       line2_q, line2_d;
    logic [63:0]       line3_q, line3_d;

    logic [63:0]       buf0_mem [LINE_WORDS];
    logic [63:0]       buf1_mem [LINE_WORDS];
    logic [63:0]       rd0_q, rd1_q;

    logic [2:0]        line_ack;
    logic [2:0]        line_done;
    logic              ready;
    logic              accept;
    logic              last_col;
    logic              wr_en;
    logic              wr_sel;

    assign line_ack  = {i_line3_data_ack, i_line2_data_ack, i_line1_data_ack};
    // a line is finished when nothing is outstanding on it or it is acked right now
    assign line_done = ~valid_q | line_ack;
    assign ready     = ~pending_q | (&line_done);
    assign accept    = i_data_valid & ready & ~i_clear & ~i_rst;
    assign last_col  = (col_q == ADDR_W'(LINE_WORDS - 1));

    assign o_data_ack         = accept;
    assign o_line1_data_valid = valid_q[0];
    assign o_line2_data_valid = valid_q[1];
    assign o_line3_data_valid = valid_q[2];
    assign o_line1_data       = line1_q;
    assign o_line2_data       = line2_q;
    assign o_line3_data       = line3_q;

    // next-state: priming/rotation FSM, column/row counters and output triple
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        rows_d    = rows_q;
        old_sel_d = old_sel_q;
        pending_d = pending_q;
        valid_d   = valid_q & ~line_ack;
        line1_d   = line1_q;
        line2_d   = line2_q;
        line3_d   = line3_q;
        wr_en     = 1'b0;
        wr_sel    = old_sel_q;

        if (&line_done) begin
            pending_d = 1'b0;
        end

        if (i_clear) begin
            state_d   = ST_FILL;
            col_d     = '0;
            rows_d    = 2'd0;
            old_sel_d = 1'b0;
            pending_d = 1'b0;
            valid_d   = 3'b000;
        end else if (accept) begin
            wr_en = 1'b1;
            col_d = last_col ? '0 : col_q + ADDR_W'(1);
            case (state_q)
                ST_FILL: begin
                    wr_sel = rows_q[0];
                    if (last_col) begin
                        rows_d = rows_q + 2'd1;
                        if (rows_q == 2'd1) begin
                            state_d   = ST_RUN;
                            old_sel_d = 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    line1_d   = old_sel_q ? rd1_q : rd0_q;
                    line2_d   = old_sel_q ? rd0_q : rd1_q;
                    line3_d   = i_data;
                    valid_d   = 3'b111;
                    pending_d = 1'b1;
                    // the write above still uses the pre-toggle selection
                    if (last_col) begin
                        old_sel_d = ~old_sel_q;
                    end
                end
                default: state_d = ST_FILL;
            endcase
        end
    end

    // state register with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_FILL;
            col_q     <= '0;
            rows_q    <= 2'd0;
            old_sel_q <= 1'b0;
            pending_q <= 1'b0;
            valid_q   <= 3'b000;
            line1_q   <= '0;
            line2_q   <= '0;
            line3_q   <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            rows_q    <= rows_d;
            old_sel_q <= old_sel_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            line1_q   <= line1_d;
            line2_q   <= line2_d;
            line3_q   <= line3_d;
        end
    end

    // line RAMs; read address looks ahead to the next column so data is ready at accept
    always_ff @(posedge i_clk) begin
        if (wr_en && !wr_sel) begin
            buf0_mem[col_q] <= i_data;
        end
        if (wr_en && wr_sel) begin
            buf1_mem[col_q] <= i_data;
        end
        rd0_q <= buf0_mem[col_d];
        rd1_q <= buf1_mem[col_d];
    end

endmodule

// File: tb/tb_line_fanout.sv
// tb/tb_line_fanout.sv - self-checking bench for line_fanout with a history-based model
module tb_line_fanout;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        v   = 1'b0;
    logic [63:0] d   = '0;
    logic        a1  = 1'b0;
    logic        a2  = 1'b0;
    logic        a3  = 1'b0;

    logic        o_ack;
    logic        o_v1, o_v2, o_v3;
    logic [63:0] o_d1, o_d2, o_d3;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: words accepted since frame start, expected valids and data
    logic [63:0] hist[$];
    logic [2:0]  mv  = 3'b000;
    logic [63:0] md1 = '0;
    logic [63:0] md2 = '0;
    logic [63:0] md3 = '0;

    always #5 clk = ~clk;

    line_fanout #(.LINE_WORDS(L), .ADDR_W(2)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_clear            (clr),
        .i_data_valid       (v),
        .i_data             (d),
        .o_data_ack         (o_ack),
        .o_line1_data_valid (o_v1),
        .o_line1_data       (o_d1),
        .i_line1_data_ack   (a1),
        .o_line2_data_valid (o_v2),
        .o_line2_data       (o_d2),
        .i_line2_data_ack   (a2),
        .o_line3_data_valid (o_v3),
        .o_line3_data       (o_d3),
        .i_line3_data_ack   (a3)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic logic model_ack();
        logic rdy;
        rdy = (~mv[0] | a1) & (~mv[1] | a2) & (~mv[2] | a3);
        return v & ~clr & ~rst & rdy;
    endfunction

    // model update: word k of a frame (k >= 2L) yields rows (k-2L, k-L, k)
    always @(posedge clk) begin
        logic acc;
        int   k;
        acc = model_ack();
        if (rst) begin
            hist.delete();
            mv  = 3'b000;
            md1 = '0;
            md2 = '0;
            md3 = '0;
        end else if (clr) begin
            hist.delete();
            mv = 3'b000;
        end else begin
            if (a1) mv[0] = 1'b0;
            if (a2) mv[1] = 1'b0;
            if (a3) mv[2] = 1'b0;
            if (acc) begin
                hist.push_back(d);
                k = hist.size() - 1;
                if (k >= 2 * L) begin
                    md1 = hist[k - 2 * L];
                    md2 = hist[k - L];
                    md3 = hist[k];
                    mv  = 3'b111;
                end
            end
        end
    end

    // compare DUT against model every cycle, mid-period
    always @(negedge clk) begin
        check("data_ack", 64'(o_ack), 64'(model_ack()));
        check("line1_valid", 64'(o_v1), 64'(mv[0]));
        check("line2_valid", 64'(o_v2), 64'(mv[1]));
        check("line3_valid", 64'(o_v3), 64'(mv[2]));
        check("line1_data", o_d1, md1);
        check("line2_data", o_d2, md2);
        check("line3_data", o_d3, md3);
    end

    task automatic send(input logic [63:0] val, output int cyc);
        logic acc;
        cyc = 0;
        v   = 1'b1;
        d   = val;
        do begin
            @(negedge clk);
            acc = o_ack;
            @(posedge clk);
            #1;
            cyc++;
        end while (!acc && cyc < 40);
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no ack for %0h expected ack within 40 cycles", val);
        end
        v = 1'b0;
    endtask

    task automatic peek(input string name, input logic [63:0] w1, input logic [63:0] w2,
                        input logic [63:0] w3);
        @(negedge clk);
        #1;
        check({name, "_valids"}, 64'({o_v3, o_v2, o_v1}), 64'd7);
        check({name, "_l1"}, o_d1, w1);
        check({name, "_l2"}, o_d2, w2);
        check({name, "_l3"}, o_d3, w3);
        @(posedge clk);
        #1;
    endtask

    task automatic prime(input logic [63:0] base);
        int c;
        int tot;
        tot = 0;
        a1 = 1'b1;
        a2 = 1'b1;
        a3 = 1'b1;
        for (int i = 0; i < 2 * L; i++) begin
            send(base + 64'(i), c);
            tot += c;
            check("prime_no_output", 64'({o_v3, o_v2, o_v1}), 64'd0);
        end
        check("prime_cycles", 64'(tot), 64'd8);
        send(base + 64'd8, c);
        peek("prime_first", base, base + 64'd4, base + 64'd8);
    endtask

    initial begin
        int c;
        int cnt;

        repeat (2) @(posedge clk);
        #1;
        check("reset_valids", 64'({o_v3, o_v2, o_v1}), 64'd0);
        check("reset_ack", 64'(o_ack), 64'd0);
        rst = 1'b0;

        prime(64'd0);

        for (int k = 9; k < 28; k++) begin
            send(64'(k), c);
            if (k == 12) peek("steady12", 64'd4, 64'd8, 64'd12);
            else if (k == 20) peek("steady20", 64'd12, 64'd16, 64'd20);
            else if (k == 24) peek("steady24", 64'd16, 64'd20, 64'd24);
            else check("steady_cycle", 64'(c), 64'd1);
        end

        send(64'd28, c);
        a2 = 1'b0;
        v  = 1'b1;
        d  = 64'd29;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("stagger_no_ack", 64'(o_ack), 64'd0);
            if (i > 0) begin
                check("stagger_l1_low", 64'(o_v1), 64'd0);
                check("stagger_l3_low", 64'(o_v3), 64'd0);
                check("stagger_l2_high", 64'(o_v2), 64'd1);
            end
            @(posedge clk);
            #1;
        end
        a2 = 1'b1;
        @(negedge clk);
        #1;
        check("stagger_release_ack", 64'(o_ack), 64'd1);
        @(posedge clk);
        #1;

        a1  = 1'b0;
        a2  = 1'b0;
        a3  = 1'b0;
        d   = 64'd30;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            cnt += int'(o_ack);
            check("hold_l3", o_d3, 64'd29);
            check("hold_l1", o_d1, 64'd21);
            @(posedge clk);
            #1;
        end
        check("hold_acks", 64'(cnt), 64'd0);
        check("hold_valids", 64'({o_v3, o_v2, o_v1}), 64'd7);
        a1 = 1'b1;
        a2 = 1'b1;
        a3 = 1'b1;
        send(64'd30, c);
        check("hold_release_cycle", 64'(c), 64'd1);

        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        for (int i = 0; i < 14; i++) send(64'(100 + i), c);
        clr = 1'b1;
        v   = 1'b1;
        d   = 64'd114;
        @(negedge clk);
        #1;
        check("clear_no_ack", 64'(o_ack), 64'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        v   = 1'b0;
        @(negedge clk);
        #1;
        check("clear_valids", 64'({o_v3, o_v2, o_v1}), 64'd0);
        @(posedge clk);
        #1;
        prime(64'd200);

        a1 = 1'b0;
        a2 = 1'b0;
        a3 = 1'b0;
        send(64'd209, c);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rst_valids", 64'({o_v3, o_v2, o_v1}), 64'd0);
        check("rst_l1", o_d1, 64'd0);
        check("rst_l2", o_d2, 64'd0);
        check("rst_l3", o_d3, 64'd0);
        @(posedge clk);
        #1;
        prime(64'd0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/line_fanout.md
# line_fanout

Upstream feeder for the three-line Laplace filter stage. It takes one 64-bit pixel stream (8 × 8-bit pixels per word, raster order) from PCIe stream 1 and buffers the two previous image lines in on-chip RAM. From the third line onward, it presents column-aligned word triples (row N-2, row N-1, row N) on three independent valid/ack line ports. Those ports connect directly to the filter's line1/line2/line3 inputs.

## Interface
- LINE_WORDS, 128: 64-bit words per image line (1024 pixels); must be ≥ 2.
- ADDR_W, 7: column address width; ≥ clog2(LINE_WORDS).
- i_clk  in  1  single clock for all logic.
- i_rst  in  1  reset, synchronous, active-high.
- i_clear  in  1  one-cycle pulse that restarts line priming (new frame).
- i_data_valid  in  1  input word valid.
- i_data  in  64  input pixel word.
- o_data_ack  out  1  input word accepted this cycle.
- o_line1_data_valid / o_line1_data  out  1 / 64  row N-2 word.
- i_line1_data_ack  in  1  consumer accepted line1 word.
- o_line2_data_valid / o_line2_data  out  1 / 64  row N-1 word.
- i_line2_data_ack  in  1  consumer accepted line2 word.
- o_line3_data_valid / o_line3_data  out  1 / 64  row N word.
- i_line3_data_ack  in  1  consumer accepted line3 word.

## Operation
- Storage: two line buffers, BUF0 and BUF1, each LINE_WORDS × 64, with a 1-cycle synchronous read. `old_sel` names the buffer holding the oldest row.
- Counters:
  - `col` runs 0..LINE_WORDS-1 and wraps to 0 on the last word of a line.
  - `rows` counts 0, 1, 2 and saturates at 2.
- FSM:
  - FILL (rows < 2): every valid word is acked and written to buffer `rows` at `col`. At end of line, `rows` increments. When `rows` becomes 2, the FSM goes to RUN with old_sel = 0.
  - RUN: a word is accepted when `ready` is high. ready = ~pending | (pending & all three lines acked or acked this cycle). On accept:
    - line1 ← BUF[old_sel][col], line2 ← BUF[~old_sel][col], line3 ← i_data, all captured into the output registers.
    - All three valids set; `pending` set.
    - i_data is written to BUF[old_sel][col].
    - `col` increments. On wrap, old_sel toggles.
- Read lookahead: the RAM read address is always the column of the next word to be accepted, so read data is ready when the accept happens. Zero bubbles.
- Per-line ack: each oN_valid clears on its own ack. `pending` clears once all three have been acked, in any order or cycles. An ack while the corresponding valid is low is ignored.
- o_data_ack = i_data_valid & ready & ~i_clear & ~i_rst (combinational).
- i_clear:
  - Sets `col`, `rows`, and old_sel to 0, the FSM to FILL, and all valids and `pending` to 0.
  - An outstanding triple is discarded. Buffer contents are not cleared.
  - If i_clear coincides with a valid input, the input is not acked.

## Timing
- Reset values: all o_lineN_data_valid = 0, all o_lineN_data = 0, FSM = FILL, col = rows = old_sel = pending = 0. o_data_ack = 0 during reset.
- Latency: an accepted word in RUN appears on all three ports in the next cycle.
- Throughput: 1 word/cycle when the consumer acks all lines in the same cycle as valid. Otherwise the next accept occurs in the cycle the last outstanding ack arrives.
- FILL absorbs 2×LINE_WORDS words at 1 word/cycle with no output.
- A line-end wrap and an accept in the same cycle: the write uses the pre-toggle old_sel. The following accept reads with the toggled old_sel.
- Mid-line i_clear: the next valid word is treated as row 0, col 0.
- Output data holds stable while its valid is high.

## Test plan
- Prime: LINE_WORDS=4. Feed 8 words with value = index, valid held high. Required: 8 acks in 8 cycles and no output valid. The 9th word (value 8) yields line1=0, line2=4, line3=8 one cycle after its ack.
- Steady stream: feed 20 words with constant all-high acks. Required: word k (k≥8) outputs (k-8, k-4, k). The fourth line's triples (12, 16, 20, …) show correct buffer rotation across wraps.
- Staggered acks: withhold line2's ack for 3 cycles while line1 and line3 ack immediately. Required: o_data_ack stays 0 until line2 acks. The next word is accepted in that same cycle, and line1/line3 valids are 0 during the wait.
- Back-pressure holding: hold all acks low for 10 cycles. Required: outputs stable, exactly one pending triple, no further input acks.
- Clear mid-line: assert i_clear at col=2 of row 3 with valid high. Required: that word not acked, all valids drop next cycle, and the next 8 words are absorbed as FILL with no output.
- Reset mid-RUN: assert i_rst with a triple pending. Required: all outputs 0 in the next cycle. Post-reset behaviour is identical to the prime test.
